mult_div: RTL and testbench

MULT_DIV -- requirements
Module: mult_div

---
 rtl/mult_div_pkg.sv | 19 +
 rtl/div_step.sv | 29 ++
 rtl/mult_div.sv | 151 +++++++++++++++
 tb/tb_mult_div.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
package mult_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int ITERATIONS = 32;
  localparam int CNT_W      = $clog2(ITERATIONS);

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and shift the quotient bit in.
module div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic [31:0] quo_next
);

  logic [32:0] shifted;
  logic [31:0] diff;
  logic        fits;

  always_comb begin
    shifted = {rem, quo[31]};
    fits    = (shifted >= {1'b0, divisor});
    // When the subtraction fits the true difference is below 2^32.
    diff    = shifted[31:0] - divisor;
    if (fits) begin
      rem_next = diff;
      quo_next = {quo[30:0], 1'b1};
    end else begin
      rem_next = shifted[31:0];
      quo_next = {quo[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring) unit with
// HI/LO result registers, one iteration per clock.
module mult_div
  import mult_div_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output state_t      fsm_state
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

  state_t            state;
  logic [CNT_W-1:0]  count;

  // Booth accumulator {A, Q, q_-1} and captured multiplicand.
  logic [64:0]       acc;
  logic [31:0]       mcand;
  logic [32:0]       booth_sum;
  logic [64:0]       booth_next;

  // Restoring divider working registers, on magnitudes.
  logic [31:0]       rem;
  logic [31:0]       quo;
  logic [31:0]       dvs;
  logic              neg_q;
  logic              neg_r;
  logic [31:0]       rem_next;
  logic [31:0]       quo_next;
  logic [31:0]       q_final;
  logic [31:0]       r_final;

  assign fsm_state = state;

  // The add/subtract is done one bit wider so that subtracting 0x80000000
  // cannot overflow before the arithmetic shift.
  always_comb begin
    booth_sum = {acc[64], acc[64:33]};
    case (acc[1:0])
      2'b01:   booth_sum = {acc[64], acc[64:33]} + {mcand[31], mcand};
      2'b10:   booth_sum = {acc[64], acc[64:33]} - {mcand[31], mcand};
      default: booth_sum = {acc[64], acc[64:33]};
    endcase
    booth_next = {booth_sum, acc[32:1]};
  end

  div_step u_div_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvs),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign q_final = neg_q ? (~quo_next + 32'd1) : quo_next;
  assign r_final = neg_r ? (~rem_next + 32'd1) : rem_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      mcand    <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mult) begin
            mcand    <= a;
            acc      <= {32'd0, b, 1'b0};
            count    <= '0;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            state    <= MULT;
          end else if (start_div) begin
            dvs      <= abs32(b);
            quo      <= abs32(a);
            rem      <= '0;
            neg_q    <= a[31] ^ b[31];
            neg_r    <= a[31];
            count    <= '0;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            state    <= DIV;
          end
        end
        MULT: begin
          acc <= booth_next;
          if (count == LAST_ITER) begin
            hi    <= booth_next[64:33];
            lo    <= booth_next[32:1];
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DIV: begin
          if (dvs == 32'd0) begin
            // Zero divisor: report it and leave HI/LO untouched.
            div_zero <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            rem <= rem_next;
            quo <= quo_next;
            if (count == LAST_ITER) begin
              hi    <= r_final;
              lo    <= q_final;
              count <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// Directed bench for mult_div: driver tasks push expected {div_zero, hi, lo}
// into a queue that a monitor pops on every done pulse.
module tb_mult_div;
  import mult_div_pkg::*;

  logic        clk;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;
  state_t      fsm_state;

  logic [64:0] exp_q[$];
  int          total;
  int          bad;

  mult_div dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .fsm_state  (fsm_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  function automatic logic [64:0] pack(input logic dz, input logic [31:0] h, input logic [31:0] l);
    return {dz, h, l};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no pending result (hi=%0h lo=%0h)", hi, lo);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        check("result_hi", 64'(hi), 64'(e[63:32]));
        check("result_lo", 64'(lo), 64'(e[31:0]));
        check("result_div_zero", 64'(div_zero), 64'(e[64]));
      end
    end
  end

  // Driver: issue one operation, wait for done, check latency and busy width.
  // poke_at >= 0 raises start_div for one cycle mid-operation.
  task automatic do_op(input string name, input logic sm, input logic sd,
                       input logic [31:0] oa, input logic [31:0] ob,
                       input logic [64:0] expv, input int exp_lat, input int poke_at);
    int lat;
    int bcnt;
    @(negedge clk);
    start_mult = sm;
    start_div  = sd;
    a          = oa;
    b          = ob;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a          = $urandom;
    b          = $urandom;
    lat  = -1;
    bcnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == poke_at) begin
        start_div = 1'b1;
        a         = $urandom_range(1, 1000);
        b         = $urandom_range(1, 9);
      end else if (i == poke_at + 1) begin
        start_div = 1'b0;
      end
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bcnt++;
    end
    start_div = 1'b0;
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat));
    @(negedge clk);
    check({name, "_done_one_cycle"}, 64'(done), 64'd0);
    check({name, "_back_to_idle"}, 64'(fsm_state), 64'(IDLE));
  endtask

  initial begin
    int done_seen;
    total      = 0;
    bad        = 0;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a          = 32'h0;
    b          = 32'h0;
    reset      = 1'b0;
    #23;
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_div_zero", 64'(div_zero), 64'd0);
    check("reset_state", 64'(fsm_state), 64'(IDLE));
    @(posedge clk);
    #1;
    reset = 1'b1;

    // 7 * -3 = -21, first start right after reset release
    do_op("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, pack(1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB), 32, -1);
    // (-2^31)^2 = 2^62
    do_op("mul_min_min", 1'b1, 1'b0, 32'h80000000, 32'h80000000, pack(1'b0, 32'h40000000, 32'h0), 32, -1);
    // -7 / 2 = -3 rem -1
    do_op("div_m7_2", 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, pack(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD), 32, -1);
    // preload 0x12345678 * 16 = 0x1_23456780
    do_op("mul_preload", 1'b1, 1'b0, 32'h12345678, 32'h10, pack(1'b0, 32'h1, 32'h23456780), 32, -1);
    // 5 / 0: flag set, HI/LO keep the preload
    do_op("div_by_zero", 1'b0, 1'b1, 32'd5, 32'd0, pack(1'b1, 32'h1, 32'h23456780), 1, -1);
    check("div_zero_held", 64'(div_zero), 64'd1);
    // both starts: multiply wins, and div_zero clears
    do_op("both_starts", 1'b1, 1'b1, 32'd6, 32'd3, pack(1'b0, 32'h0, 32'd18), 32, -1);
    // -2^31 / -1 wraps to -2^31, rem 0
    do_op("div_min_m1", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, pack(1'b0, 32'h0, 32'h80000000), 32, -1);
    // 100 / -7 = -14 rem 2
    do_op("div_100_m7", 1'b0, 1'b1, 32'd100, 32'hFFFFFFF9, pack(1'b0, 32'd2, 32'hFFFFFFF2), 32, -1);
    // -100 / -7 = 14 rem -2
    do_op("div_m100_m7", 1'b0, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, pack(1'b0, 32'hFFFFFFFE, 32'd14), 32, -1);
    // -1 * 0x7FFFFFFF = -0x7FFFFFFF
    do_op("mul_m1_max", 1'b1, 1'b0, 32'hFFFFFFFF, 32'h7FFFFFFF, pack(1'b0, 32'hFFFFFFFF, 32'h80000001), 32, -1);

    // Reset during iteration 10 of a divide: no result expected.
    @(negedge clk);
    start_div = 1'b1;
    a         = 32'd1000;
    b         = 32'd3;
    @(posedge clk);
    #1;
    start_div = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_hi", 64'(hi), 64'd0);
    check("midreset_lo", 64'(lo), 64'd0);
    check("midreset_state", 64'(fsm_state), 64'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("midreset_no_done", 64'(done_seen), 64'd0);
    check("midreset_hi_kept", 64'(hi), 64'd0);

    // start_div pulsed at iteration 5 of a multiply is ignored
    do_op("mul_ignore_div", 1'b1, 1'b0, 32'd5, 32'd9, pack(1'b0, 32'h0, 32'd45), 32, 5);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("ignored_start_no_done", 64'(done_seen), 64'd0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
